// File: rtl/spi_frame_buffer.sv
// -----------------------------------------------------------------------------
// spi_frame_buffer
//
// Ping-pong frame store behind the SPI word receiver. Each word flagged by
// write_pulse is written into one of two RAM banks. A bank is handed to the
// local reader only once it holds FRAME_WORDS words. The reader then streams
// that frame out over a valid/ready interface while the SPI side fills the
// other bank. When both banks are occupied, incoming words are dropped and
// counted.
//
// Ports:
//   clk_50        in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   write_pulse   in   one-cycle strobe, data valid this cycle
//   data[15:0]    in   received word
//   rd_data[15:0] out  frame word to consumer
//   rd_valid      out  rd_data valid
//   rd_ready      in   consumer accepts when rd_valid && rd_ready
//   rd_last       out  rd_data is final word of the frame
//   frames_done   out  frames fully written (wrapping)
//   dropped_words out  words discarded on overflow (saturating)
//   overflow      out  sticky overflow flag
// -----------------------------------------------------------------------------
module spi_frame_buffer #(
    parameter int FRAME_WORDS = 1024,
    parameter int BANK_AW     = 10
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        write_pulse,
    input  logic [15:0] data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic [15:0] frames_done,
    output logic [15:0] dropped_words,
    output logic        overflow
);

    localparam logic [BANK_AW-1:0] LAST_PTR = BANK_AW'(FRAME_WORDS - 1);

    typedef enum logic {W_FILL, W_WAIT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} r_state_t;

    w_state_t           w_state_reg, w_state_next;
    r_state_t           r_state_reg, r_state_next;
    logic               wr_bank_reg, wr_bank_next;
    logic               rd_bank_reg, rd_bank_next;
    logic [BANK_AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [BANK_AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [1:0]         bank_full_reg, bank_full_next;
    logic [15:0]        rd_data_reg, rd_data_next;
    logic               rd_valid_reg, rd_valid_next;
    logic               rd_last_reg, rd_last_next;
    logic [15:0]        frames_done_reg, frames_done_next;
    logic [15:0]        dropped_reg, dropped_next;
    logic               overflow_reg, overflow_next;

    // RAM port controls
    logic               mem_we;
    logic [BANK_AW:0]   mem_waddr;
    logic               mem_re;
    logic [BANK_AW:0]   mem_raddr;
    logic [15:0]        mem_q;

    // Reader hands its bank back this cycle (last word accepted)
    logic               bank_release;
    // Writer completes a frame this cycle
    logic               set_full;
    // Bank opposite to the writer is (or becomes this cycle) free
    logic               other_free;
    logic               other_released;
    logic [BANK_AW-1:0] rd_ptr_inc;

    // -------------------------------------------------------------------------
    // Frame RAM: one write port, one registered read port
    // -------------------------------------------------------------------------
    logic [15:0] mem [0:2*FRAME_WORDS-1];

    always_ff @(posedge clk_50) begin
        if (mem_we) begin
            mem[mem_waddr] <= data;
        end
        if (mem_re) begin
            mem_q <= mem[mem_raddr];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (reset) begin
            w_state_reg     <= W_FILL;
            r_state_reg     <= R_IDLE;
            wr_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            bank_full_reg   <= 2'b00;
            rd_data_reg     <= 16'h0000;
            rd_valid_reg    <= 1'b0;
            rd_last_reg     <= 1'b0;
            frames_done_reg <= 16'h0000;
            dropped_reg     <= 16'h0000;
            overflow_reg    <= 1'b0;
        end else begin
            w_state_reg     <= w_state_next;
            r_state_reg     <= r_state_next;
            wr_bank_reg     <= wr_bank_next;
            rd_bank_reg     <= rd_bank_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            bank_full_reg   <= bank_full_next;
            rd_data_reg     <= rd_data_next;
            rd_valid_reg    <= rd_valid_next;
            rd_last_reg     <= rd_last_next;
            frames_done_reg <= frames_done_next;
            dropped_reg     <= dropped_next;
            overflow_reg    <= overflow_next;
        end
    end

    // -------------------------------------------------------------------------
    // Reader FSM
    // -------------------------------------------------------------------------
    assign rd_ptr_inc = rd_ptr_reg + BANK_AW'(1);

    always_comb begin
        r_state_next = r_state_reg;
        rd_bank_next = rd_bank_reg;
        rd_ptr_next  = rd_ptr_reg;
        rd_data_next = rd_data_reg;
        rd_valid_next = rd_valid_reg;
        rd_last_next = rd_last_reg;
        mem_re       = 1'b0;
        mem_raddr    = {rd_bank_reg, rd_ptr_reg};
        bank_release = 1'b0;

        case (r_state_reg)
            R_IDLE: begin
                if (bank_full_reg[rd_bank_reg]) begin
                    mem_re       = 1'b1;
                    r_state_next = R_READ;
                end
            end
            R_READ: begin
                rd_data_next  = mem_q;
                rd_valid_next = 1'b1;
                rd_last_next  = (rd_ptr_reg == LAST_PTR);
                r_state_next  = R_HOLD;
            end
            R_HOLD: begin
                // rd_valid is always high here, so rd_ready alone is the handshake
                if (rd_ready) begin
                    rd_valid_next = 1'b0;
                    if (!rd_last_reg) begin
                        rd_ptr_next  = rd_ptr_inc;
                        mem_re       = 1'b1;
                        mem_raddr    = {rd_bank_reg, rd_ptr_inc};
                        r_state_next = R_READ;
                    end else begin
                        bank_release = 1'b1;
                        rd_ptr_next  = '0;
                        rd_bank_next = ~rd_bank_reg;
                        r_state_next = R_IDLE;
                    end
                end
            end
            default: begin
                r_state_next = R_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Writer FSM
    // -------------------------------------------------------------------------
    // A release by the reader in this very cycle counts as free, so a frame
    // completing at the same moment switches banks without dropping anything.
    assign other_released = bank_release && (rd_bank_reg == ~wr_bank_reg);
    assign other_free     = !bank_full_reg[~wr_bank_reg] || other_released;

    always_comb begin
        w_state_next     = w_state_reg;
        wr_bank_next     = wr_bank_reg;
        wr_ptr_next      = wr_ptr_reg;
        frames_done_next = frames_done_reg;
        dropped_next     = dropped_reg;
        overflow_next    = overflow_reg;
        mem_we           = 1'b0;
        mem_waddr        = {wr_bank_reg, wr_ptr_reg};
        set_full         = 1'b0;

        case (w_state_reg)
            W_FILL: begin
                if (write_pulse) begin
                    mem_we = 1'b1;
                    if (wr_ptr_reg == LAST_PTR) begin
                        wr_ptr_next      = '0;
                        set_full         = 1'b1;
                        frames_done_next = frames_done_reg + 16'd1;
                        if (other_free) begin
                            wr_bank_next = ~wr_bank_reg;
                        end else begin
                            w_state_next = W_WAIT;
                        end
                    end else begin
                        wr_ptr_next = wr_ptr_reg + BANK_AW'(1);
                    end
                end
            end
            W_WAIT: begin
                // Words arriving here, including the release cycle, are lost
                if (write_pulse) begin
                    overflow_next = 1'b1;
                    if (dropped_reg != 16'hFFFF) begin
                        dropped_next = dropped_reg + 16'd1;
                    end
                end
                if (other_released) begin
                    wr_bank_next = ~wr_bank_reg;
                    w_state_next = W_FILL;
                end
            end
            default: begin
                w_state_next = W_FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bank occupancy. Writer and reader never target the same bank at once,
    // so set and clear cannot collide on one flag.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_full
            assign bank_full_next[gi] =
                (bank_full_reg[gi] && !(bank_release && (rd_bank_reg == 1'(gi))))
                || (set_full && (wr_bank_reg == 1'(gi)));
        end
    endgenerate

    assign rd_data       = rd_data_reg;
    assign rd_valid      = rd_valid_reg;
    assign rd_last       = rd_last_reg;
    assign frames_done   = frames_done_reg;
    assign dropped_words = dropped_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_buffer
//
// Scoreboard bench for spi_frame_buffer with 4-word frames. Every word the
// writer is expected to store is queued with its expected rd_last flag; the
// read monitor pops and compares on each accepted output word.
// -----------------------------------------------------------------------------
module tb_spi_frame_buffer;

    localparam int FW = 4;

    logic        clk_50;
    logic        reset;
    logic        write_pulse;
    logic [15:0] data;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic [15:0] frames_done;
    logic [15:0] dropped_words;
    logic        overflow;

    spi_frame_buffer #(
        .FRAME_WORDS(FW),
        .BANK_AW    (2)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .write_pulse  (write_pulse),
        .data         (data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .frames_done  (frames_done),
        .dropped_words(dropped_words),
        .overflow     (overflow)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   stored_idx;
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Read monitor: handshake values are sampled half a cycle before the edge
    always @(negedge clk_50) begin : mon
        exp_t e;
        if (!reset && rd_valid && rd_ready) begin
            if (q.size() == 0) begin
                check("rd_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                $display("RD data=%h last=%b expect=%h/%b", rd_data, rd_last, e.d, e.l);
                check("rd_data", {16'd0, rd_data}, {16'd0, e.d});
                check("rd_last", {31'd0, rd_last}, {31'd0, e.l});
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        write_pulse = 1'b0;
        @(posedge clk_50); #1;
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_last", {31'd0, rd_last}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_frames_done", {16'd0, frames_done}, 32'd0);
        check("rst_dropped", {16'd0, dropped_words}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        q.delete();
        stored_idx = 0;
    endtask

    task automatic write_word(input logic [15:0] wd, input bit stored);
        $display("WR data=%h stored=%0d", wd, stored);
        if (stored) begin
            q.push_back('{d: wd, l: ((stored_idx % FW) == FW - 1)});
            stored_idx++;
        end
        write_pulse = 1'b1;
        data        = wd;
        @(posedge clk_50); #1;
        write_pulse = 1'b0;
    endtask

    task automatic wait_size(input int target, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (q.size() <= target) break;
            @(posedge clk_50); #1;
        end
        check(tag, q.size(), target);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (rd_valid) break;
            @(posedge clk_50); #1;
        end
        check(tag, {31'd0, rd_valid}, 32'd1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        stored_idx  = 0;
        reset       = 1'b1;
        write_pulse = 1'b0;
        data        = 16'h0000;
        rd_ready    = 1'b0;
        repeat (2) @(posedge clk_50);
        #1;

        // 1: single frame, consumer always ready
        do_reset();
        rd_ready = 1'b1;
        write_word(16'h1111, 1);
        write_word(16'h2222, 1);
        write_word(16'h3333, 1);
        write_word(16'h4444, 1);
        wait_size(0, "t1_drain");
        check("t1_frames_done", {16'd0, frames_done}, 32'd1);
        check("t1_overflow", {31'd0, overflow}, 32'd0);

        // 2: both banks filled with consumer stalled, then drained
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(16'h00A0 + 16'(i), 1);
        check("t2_frames_done", {16'd0, frames_done}, 32'd2);
        check("t2_dropped", {16'd0, dropped_words}, 32'd0);
        rd_ready = 1'b1;
        wait_size(0, "t2_drain");
        check("t2_overflow", {31'd0, overflow}, 32'd0);

        // 3: overflow, then recovery into bank 0
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_word(16'h00C0 + 16'(i), i < 8);
        check("t3_frames_done", {16'd0, frames_done}, 32'd2);
        check("t3_dropped", {16'd0, dropped_words}, 32'd2);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        rd_ready = 1'b1;
        wait_size(4, "t3_bank0_drained");
        for (int i = 0; i < 4; i++) write_word(16'h00D0 + 16'(i), 1);
        wait_size(0, "t3_drain");
        check("t3_frames_done_after", {16'd0, frames_done}, 32'd3);
        check("t3_dropped_after", {16'd0, dropped_words}, 32'd2);
        check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 4: consumer stalls five cycles mid-frame
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(16'h00E0 + 16'(i), 1);
        wait_size(2, "t4_half");
        rd_ready = 1'b0;
        wait_valid("t4_valid_seen");
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", {31'd0, rd_valid}, 32'd1);
            check("t4_stall_data", {16'd0, rd_data}, {16'd0, q[0].d});
            check("t4_stall_last", {31'd0, rd_last}, {31'd0, q[0].l});
            @(posedge clk_50); #1;
        end
        rd_ready = 1'b1;
        wait_size(0, "t4_drain");

        // 5: reset during a partial frame with output valid
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(16'h00F0 + 16'(i), 1);
        write_word(16'h0070, 1);
        write_word(16'h0071, 1);
        wait_valid("t5_valid_before_reset");
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(16'h00B0 + 16'(i), 1);
        wait_size(0, "t5_drain");
        check("t5_frames_done", {16'd0, frames_done}, 32'd1);

        // 6: release and frame completion in the same cycle
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) write_word(16'h0050 + 16'(i), 1);
        wait_valid("t6_first_valid");
        rd_ready = 1'b1;
        wait_size(4, "t6_three_out");
        rd_ready = 1'b0;
        wait_valid("t6_last_valid");
        check("t6_last_is_last", {31'd0, rd_last}, 32'd1);
        rd_ready = 1'b1;
        write_word(16'h0057, 1);
        for (int i = 8; i < 12; i++) write_word(16'h0050 + 16'(i), 1);
        wait_size(0, "t6_drain");
        check("t6_frames_done", {16'd0, frames_done}, 32'd3);
        check("t6_dropped", {16'd0, dropped_words}, 32'd0);
        check("t6_overflow", {31'd0, overflow}, 32'd0);

        repeat (4) @(posedge clk_50);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_buffer.md
Name: spi_frame_buffer

Overview:
- Downstream consumer of the SPI word receiver: takes each 16-bit word flagged by the receiver's one-cycle write pulse and stores it in a two-bank (ping-pong) on-chip RAM.
- A bank is handed to the local reader only once it holds a complete frame of FRAME_WORDS words.
- The reader streams the frame out over a valid/ready interface while the SPI side fills the other bank.
- Tracks completed frames and flags overflow when both banks are occupied.

Parameters:
- FRAME_WORDS, 1024, words per frame (per bank); power of two, >= 2.
- BANK_AW, 10, bank address width; must equal log2(FRAME_WORDS).

Ports:
- clk_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write_pulse  in  1  one-cycle strobe from SPI receiver; word on data is valid this cycle.
- data  in  16  received word, sampled when write_pulse=1.
- rd_data  out  16  frame word to consumer.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts word when rd_valid && rd_ready.
- rd_last  out  1  qualifies rd_data as final word of frame.
- frames_done  out  16  count of frames fully written; wraps 0xFFFF->0.
- dropped_words  out  16  words discarded due to overflow; saturates at 0xFFFF.
- overflow  out  1  sticky; set on first dropped word, cleared only by reset.

Behaviour:
- Reset (clk_50 edge with reset=1), regardless of state:
  - rd_valid=0, rd_last=0, rd_data=0, frames_done=0, dropped_words=0, overflow=0.
  - Both banks marked free; wr_bank=0, rd_bank=0, write/read pointers=0.
  - Writer goes to W_FILL; reader goes to R_IDLE.
  - Any partial frame is discarded.
- Storage: 2*FRAME_WORDS x 16 RAM; physical address = {bank, ptr}; synchronous read, 1-cycle latency; one write and one read port.
- Writer FSM:
  - W_FILL: on write_pulse, write data to {wr_bank, wr_ptr} and increment wr_ptr.
  - When the word at wr_ptr=FRAME_WORDS-1 is written:
    - mark wr_bank full; wr_ptr<=0; frames_done+1.
    - If the other bank is free this cycle (including a release by the reader in the same cycle): wr_bank toggles; stay in W_FILL.
    - Otherwise go to W_WAIT.
  - W_WAIT: write_pulse words are not stored; dropped_words+1 (saturating); overflow<=1.
    - When the reader releases the other bank: wr_bank toggles, go to W_FILL next cycle.
    - A word arriving in the release cycle is dropped.
- Reader FSM (words every 2 cycles min; acceptable against SPI rate):
  - R_IDLE: if bank rd_bank is full, issue RAM read at {rd_bank, rd_ptr}, go to R_READ.
  - R_READ: capture RAM output into rd_data; rd_valid<=1; rd_last<=(rd_ptr==FRAME_WORDS-1); go to R_HOLD.
  - R_HOLD: rd_data/rd_last held stable while rd_valid && !rd_ready. On handshake: rd_valid<=0.
    - If not last: rd_ptr+1, issue next read, go to R_READ.
    - If last: mark rd_bank free, rd_ptr<=0, rd_bank toggles, go to R_IDLE.
- Bank release and writer completion in the same cycle: the writer sees the bank free and switches without entering W_WAIT.
- Frames are delivered strictly in completion order; bank 0 is always first after reset.
- rd_ready is ignored when rd_valid=0.
- write_pulse pulses closer than 1 cycle apart cannot occur; back-to-back pulses on consecutive cycles must still each be stored.

Test Plan (FRAME_WORDS=4, BANK_AW=2):
- Reset, then 4 pulses with data 0x1111,0x2222,0x3333,0x4444, rd_ready=1 -> frames_done=1; rd_data sequence 1111,2222,3333,4444 with rd_last only on 0x4444; overflow=0.
- rd_ready=0, write 8 words 0xA0..0xA7 -> frames_done=2, no drops; then rd_ready=1 -> A0..A7 out in order, rd_last on A3 and A7.
- rd_ready=0, write 10 words -> frames_done=2, dropped_words=2, overflow=1; after draining bank 0, next 4 writes land in bank 0 and frames_done=3.
- Hold rd_ready=0 for 5 cycles mid-frame -> rd_data, rd_valid and rd_last stable throughout; no word skipped or duplicated.
- Reset asserted after 2 words of a frame and while rd_valid=1 -> next cycle all outputs 0; 4 new words 0xB0..0xB3 form frame 1 from bank 0.
- Reader releases bank on the same cycle the writer writes its 4th word while the other bank is full -> no drop; writer continues into the freed bank.
